bcd_xs3_serial_conv: RTL and testbench

Multi-digit, bidirectional BCD / Excess-3 code converter with valid/ready handshakes on both sides. It accepts a packed word of `DIGITS` 4-bit digits and converts one digit per clock, least-significant digit first. The mode is selectable per word: BCD→XS3 or XS3→BCD. Invalid input codes are flagged per digit instead of producing undefined outputs. It sits between the digit-entry/display datapath blocks and any stage that needs self-complementing Excess-3 arithmetic.

---
 rtl/bcd_xs3_pkg.sv | 22 ++
 rtl/bcd_xs3_digit.sv | 35 +++
 rtl/bcd_xs3_serial_conv.sv | 138 +++++++++++++
 tb/tb_bcd_xs3_serial_conv.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_pkg.sv
// Purpose: shared types and code constants for the serial BCD / Excess-3 converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_xs3_pkg;

    typedef enum logic {
        MODE_BCD2XS3 = 1'b0,
        MODE_XS32BCD = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/bcd_xs3_digit.sv
// Purpose: single-digit BCD<->Excess-3 converter with code validity check.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the result.
//
// Ports:
//   mode_i   : conversion direction (MODE_BCD2XS3 / MODE_XS32BCD)
//   digit_i  : 4-bit input code
//   result_o : converted code, 4'b0000 when the input code is invalid
//   valid_o  : high when digit_i is a legal code for the selected direction
module bcd_xs3_digit
    import bcd_xs3_pkg::*;
(
    input  mode_e      mode_i,
    input  logic [3:0] digit_i,
    output logic [3:0] result_o,
    output logic       valid_o
);

    always_comb begin
        result_o = 4'b0000;
        valid_o  = 1'b0;
        if (mode_i == MODE_BCD2XS3) begin
            valid_o = (digit_i <= BCD_MAX);
            if (valid_o) begin
                result_o = digit_i + XS3_OFFSET;
            end
        end else begin
            valid_o = (digit_i >= XS3_MIN) && (digit_i <= XS3_MAX);
            if (valid_o) begin
                result_o = digit_i - XS3_OFFSET;
            end
        end
    end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Purpose: multi-digit BCD<->Excess-3 converter, one digit per clock, LSD first.
// Latency: DIGITS cycles from input accept to out_valid; one word per DIGITS+2 cycles at best.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : input handshake; in_mode and in_data sampled on accept
//   out_valid/out_ready : output handshake for out_data / out_err_mask / out_err
//   out_err_mask      : per-digit invalid-code flags, out_err is their OR
module bcd_xs3_serial_conv
    import bcd_xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
);

    localparam int CW = $clog2(DIGITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   cap_q, cap_d;
    mode_e                 mode_q, mode_d;
    logic [4*DIGITS-1:0]   res_q, res_d;
    logic [DIGITS-1:0]     mask_q, mask_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [3:0]            cur_digit;
    logic [3:0]            cur_result;
    logic                  cur_valid;

    // Select the captured digit addressed by the counter.
    always_comb begin
        cur_digit = 4'b0000;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                cur_digit = cap_q[4*i +: 4];
            end
        end
    end

    bcd_xs3_digit u_digit (
        .mode_i   (mode_q),
        .digit_i  (cur_digit),
        .result_o (cur_result),
        .valid_o  (cur_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        mode_d      = mode_q;
        res_d       = res_q;
        mask_d      = mask_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_d   = in_data;
                    mode_d  = mode_e'(in_mode);
                    res_d   = '0;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[4*i +: 4] = cur_result;
                        mask_d[i]       = ~cur_valid;
                    end
                end
                // Counter parks on the last digit rather than wrapping.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state, so no
        // input reaches an output combinationally.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_q       <= '0;
            mode_q      <= MODE_BCD2XS3;
            res_q       <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            mode_q      <= mode_d;
            res_q       <= res_d;
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = res_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
module tb_bcd_xs3_serial_conv;

    localparam int DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [3:0]  out_err_mask;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    bcd_xs3_serial_conv #(.DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err_mask (out_err_mask),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    // Reference: per-digit arithmetic straight from the code definitions.
    function automatic void model(input logic [15:0] d, input logic m,
                                  output logic [15:0] r, output logic [3:0] k);
        r = 16'h0;
        k = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            int v;
            v = int'(d[4*i +: 4]);
            if (m == 1'b0) begin
                if (v <= 9) r[4*i +: 4] = 4'(v + 3);
                else        k[i] = 1'b1;
            end else begin
                if (v >= 3 && v <= 12) r[4*i +: 4] = 4'(v - 3);
                else                   k[i] = 1'b1;
            end
        end
    endfunction

    // Offer one word, wait for the result; all signals sampled on negedge.
    task automatic run_word(input logic [15:0] d, input logic m,
                            output logic [15:0] od, output logic [3:0] om,
                            output logic oe, output int lat, output bit tmo);
        int n;
        tmo = 0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hxxxx;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) tmo = 1;
        od = out_data;
        om = out_err_mask;
        oe = out_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        total++; if (out_err_mask !== 4'h0 || out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b/%b exp=0000/0", out_err_mask, out_err); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_flags got=%b%b exp=10", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] vd [6] = '{16'h1234, 16'h4567, 16'h0000, 16'h9999, 16'h9A05, 16'h0C3F};
        logic        vm [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] ed [6] = '{16'h4567, 16'h1234, 16'h3333, 16'hCCCC, 16'hC038, 16'h0900};
        logic [3:0]  em [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1001};
        logic [15:0] od; logic [3:0] om; logic oe; int lat; bit tmo;
        for (int i = 0; i < 6; i++) begin
            run_word(vd[i], vm[i], od, om, oe, lat, tmo);
            total++; if (tmo) begin bad++; $display("FAIL dir%0d_timeout no out_valid within 50 cycles", i); end
            total++; if (lat != DIGITS) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, DIGITS); end
            total++; if (od !== ed[i]) begin bad++; $display("FAIL dir%0d_data in=%h got=%h exp=%h", i, vd[i], od, ed[i]); end
            total++; if (om !== em[i] || oe !== (|em[i])) begin bad++; $display("FAIL dir%0d_mask got=%b/%b exp=%b/%b", i, om, oe, em[i], |em[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d, od, ed; logic m, oe; logic [3:0] om, em; int lat; bit tmo;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            m = 1'($urandom);
            model(d, m, ed, em);
            run_word(d, m, od, om, oe, lat, tmo);
            total++; if (tmo || lat != DIGITS) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d tmo=%0d", i, lat, DIGITS, tmo); end
            total++; if (od !== ed || om !== em || oe !== (|em)) begin
                bad++; $display("FAIL rnd%0d_result in=%h mode=%b got=%h/%b/%b exp=%h/%b/%b", i, d, m, od, om, oe, ed, em, |em);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, od, ed; logic m, oe; logic [3:0] om, em; int lat; bit tmo;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            m = 1'($urandom);
            model(d, m, ed, em);
            run_word(d, m, od, om, oe, lat, tmo);
            total++; if (tmo || od !== ed || om !== em) begin bad++; $display("FAIL b2b%0d_result got=%h/%b exp=%h/%b", i, od, om, ed, em); end
            // out_ready is high, so the word leaves on the next edge.
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_release got=v%b r%b exp=v0 r1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] od, ed; logic [3:0] om, em; logic oe; int lat; bit tmo; int seen;
        out_ready = 1'b0;
        run_word(16'h1234, 1'b0, od, om, oe, lat, tmo);
        total++; if (tmo || od !== 16'h4567) begin bad++; $display("FAIL bp_first got=%h exp=4567 tmo=%0d", od, tmo); end
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_mode  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_flags got=v%b r%b exp=v1 r0", i, out_valid, in_ready); end
            total++; if (out_data !== 16'h4567 || out_err_mask !== 4'h0) begin bad++; $display("FAIL bp_hold%0d_data got=%h/%b exp=4567/0000", i, out_data, out_err_mask); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL bp_no_extra_word got=%0d valid cycles exp=0", seen); end
        model(16'h2468, 1'b1, ed, em);
        run_word(16'h2468, 1'b1, od, om, oe, lat, tmo);
        total++; if (tmo || od !== ed || om !== em) begin bad++; $display("FAIL bp_next got=%h/%b exp=%h/%b", od, om, ed, em); end
    endtask

    task automatic test_reset_mid_conv();
        logic [15:0] od; logic [3:0] om; logic oe; int lat; bit tmo; int seen;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        in_mode  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmc_flags got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        total++; if (out_data !== 16'h0 || out_err_mask !== 4'h0) begin bad++; $display("FAIL rmc_data got=%h/%b exp=0000/0000", out_data, out_err_mask); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rmc_aborted got=%0d valid cycles exp=0", seen); end
        run_word(16'h0001, 1'b0, od, om, oe, lat, tmo);
        total++; if (tmo || od !== 16'h3334 || om !== 4'h0) begin bad++; $display("FAIL rmc_next got=%h/%b exp=3334/0000", od, om); end
    endtask

    task automatic test_reset_in_done();
        logic [15:0] od; logic [3:0] om; logic oe; int lat; bit tmo;
        out_ready = 1'b0;
        run_word(16'h0C3F, 1'b1, od, om, oe, lat, tmo);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        total++; if (out_valid !== 1'b0 || out_data !== 16'h0 || out_err !== 1'b0) begin
            bad++; $display("FAIL rdone got=v%b %h e%b exp=v0 0000 e0", out_valid, out_data, out_err);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_conv();
        test_reset_in_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
